ndn_packet_parser: RTL and testbench
====================================

# ndn_packet_parser

Byte-stream front end of the NDN router. It accepts a serial packet stream from the line interface, decodes interest and data packet headers, and drives the router's interest inputs (`prefix`, `len`, `out_bit`) and data inputs (`data_in_prefix`, `data_in_len`, `data_ready`, `in_data`). Content bytes are forwarded one per cycle under the router's `ready_for_data` backpressure. Malformed packets are consumed and flagged.

## Interface
- `INTEREST_TYPE`, default 8'h05: type byte identifying an interest packet.
- `DATA_TYPE`, default 8'h06: type byte identifying a data packet.
- `MAX_NAME_BYTES`, default 7: largest legal name length N, in bytes. It must be ≤ 7 so that N*8 fits in 6 bits.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_byte`  in  8  incoming stream byte.
- `rx_valid`  in  1  `rx_byte` is valid.
- `rx_ready`  out  1  parser accepts `rx_byte` this cycle. A byte transfers when `rx_valid & rx_ready`.
- `ready_for_data`  in  1  router can take a content byte.
- `prefix`  out  64  interest name, left-aligned.
- `len`  out  6  interest name length in bits.
- `out_bit`  out  1  one-cycle strobe: `prefix`/`len` are valid.
- `data_in_prefix`  out  64  data packet name, left-aligned.
- `data_in_len`  out  6  data packet name length in bits.
- `data_ready`  out  1  `in_data` is valid this cycle.
- `in_data`  out  8  content byte.
- `parse_err`  out  1  one-cycle strobe on a malformed packet.

## Operation
- Packet format is byte-serial:
  - Byte 0 is TYPE.
  - Byte 1 is N, the name length in bytes.
  - The next N bytes are the name.
  - Data packets only: one byte M (content length), then M content bytes.
- Name packing:
  - Name byte k (k = 0 first) is written to `prefix[63-8k -: 8]`.
  - Unused low bytes are zero.
  - `len = N*8`, giving legal values 8..56.
- State machine: IDLE, NLEN, NAME, CLEN, CONTENT, DROP.
  - IDLE: accept TYPE. If TYPE matches either parameter, go to NLEN. Otherwise pulse `parse_err` and stay in IDLE.
  - NLEN: N = 0 or N > `MAX_NAME_BYTES` pulses `parse_err`.
    - If N = 0, go to IDLE.
    - Otherwise load byte counter = N and go to DROP.
    - A legal N clears the name shift register, loads the counter, and goes to NAME.
  - NAME: store each byte and decrement the counter. On the last byte:
    - Interest: update `prefix`/`len`, pulse `out_bit`, go to IDLE.
    - Data: update `data_in_prefix`/`data_in_len`, go to CLEN.
  - CLEN: M = 0 pulses `parse_err` and goes to IDLE. Otherwise load counter = M and go to CONTENT.
  - CONTENT: each accepted byte is presented on `in_data` with `data_ready` = 1 for one cycle. After M bytes, go to IDLE.
  - DROP: discard the counted bytes, then go to IDLE. Nothing else is driven.
- `rx_ready` is 1 in every state except CONTENT, where `rx_ready = ready_for_data`.
- `prefix`/`len` hold their value until the next interest completes. `data_in_prefix`/`data_in_len` hold until the next data name completes, so they stay stable throughout CONTENT.
- Byte counter: 8 bits, down-counting. The transition fires when the counter equals 1 and a byte is accepted.

## Timing
- Reset (asynchronous assert, `rst` = 0):
  - State goes to IDLE and the counter to 0.
  - `prefix`, `data_in_prefix`, `len`, `data_in_len`, `in_data` are 0.
  - `out_bit`, `data_ready`, `parse_err` are 0.
  - `rx_ready` is 1 once `rst` = 1.
- Reset mid-packet abandons the packet. The first byte after release is parsed as TYPE.
- All outputs are registered:
  - `out_bit` is high in the cycle after the last name byte is accepted, together with the updated `prefix`/`len`.
  - `data_ready`/`in_data` appear the cycle after the content byte is accepted.
  - `parse_err` appears the cycle after the offending byte is accepted.
- If `rx_valid` = 0 mid-packet, the state holds indefinitely. There is no timeout.
- If `ready_for_data` drops during CONTENT, no byte is accepted, and `data_ready` is 0 from the next cycle.
- Back-to-back packets: TYPE of the next packet may be accepted in the cycle right after the last byte of the previous one. Throughput is one byte per cycle.
- Strobes are never stretched. Two consecutive interests each produce a distinct `out_bit` pulse.

## Test plan
- Interest: stream 05,03,AA,BB,CC with `rx_valid` held high. Require `out_bit` = 1 for exactly one cycle, `prefix` = AABBCC0000000000, `len` = 24, and `data_ready` never high.
- Data with backpressure: stream 06,02,12,34,03,D0,D1,D2 and drop `ready_for_data` for 2 cycles after D0. Require:
  - `data_in_prefix` = 1234000000000000 and `data_in_len` = 16.
  - `in_data` = D0, D1, D2, each with a single `data_ready` pulse.
  - `rx_ready` = 0 during the stall and no byte lost.
- Bad type: stream 07 then a legal interest. Require one `parse_err` pulse, then a correct `out_bit` for the interest.
- Oversize name: stream 05,09 followed by 9 bytes, then interest 05,01,7F. Require one `parse_err`, no `out_bit` for the first packet, then `prefix` = 7F00000000000000 and `len` = 8.
- Boundaries:
  - N = 7 gives `len` = 56 with the low byte 00.
  - N = 0 gives `parse_err` and a return to IDLE.
  - M = 0 gives `parse_err` with `data_in_prefix` still updated.
- Reset: assert `rst` = 0 after 2 name bytes of an interest. Require all outputs 0 immediately (asynchronous), then a fresh interest parses correctly.

Source files
------------

// File: rtl/ndn_packet_parser.sv
// Byte-serial NDN packet front end: decodes interest/data headers, forwards
// content bytes under router backpressure and flags malformed packets.
module ndn_packet_parser #(
    parameter logic [7:0] INTEREST_TYPE  = 8'h05,
    parameter logic [7:0] DATA_TYPE      = 8'h06,
    parameter int         MAX_NAME_BYTES = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        ready_for_data,
    output logic [63:0] prefix,
    output logic [5:0]  len,
    output logic        out_bit,
    output logic [63:0] data_in_prefix,
    output logic [5:0]  data_in_len,
    output logic        data_ready,
    output logic [7:0]  in_data,
    output logic        parse_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_NLEN    = 3'd1;
    localparam logic [2:0] S_NAME    = 3'd2;
    localparam logic [2:0] S_CLEN    = 3'd3;
    localparam logic [2:0] S_CONTENT = 3'd4;
    localparam logic [2:0] S_DROP    = 3'd5;

    localparam logic [7:0] MAX_N = 8'(MAX_NAME_BYTES);

    logic [2:0]  r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_idx;
    logic [2:0]  r_nlen;
    logic        r_is_data;
    logic [63:0] r_name;

    logic        w_accept;
    logic        w_last;
    logic        w_type_ok;
    logic [5:0]  w_slot;
    logic [5:0]  w_len;
    logic [63:0] w_name_next;

    assign rx_ready  = (r_state != S_CONTENT) || ready_for_data;
    assign w_accept  = rx_valid && rx_ready;
    assign w_last    = (r_cnt == 8'd1);
    assign w_type_ok = (rx_byte == INTEREST_TYPE) || (rx_byte == DATA_TYPE);
    // Name byte k lands at bit 63-8k; ~r_idx is 7-k for a 3-bit index.
    assign w_slot    = {~r_idx, 3'b000};
    assign w_len     = {r_nlen, 3'b000};

    // NOTE: default first so every path assigns w_name_next; no latch is inferred.
    always_comb begin
        w_name_next                = r_name;
        w_name_next[w_slot +: 8]   = rx_byte;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= 8'd0;
            r_idx          <= 3'd0;
            r_nlen         <= 3'd0;
            r_is_data      <= 1'b0;
            r_name         <= 64'd0;
            prefix         <= 64'd0;
            len            <= 6'd0;
            out_bit        <= 1'b0;
            data_in_prefix <= 64'd0;
            data_in_len    <= 6'd0;
            data_ready     <= 1'b0;
            in_data        <= 8'd0;
            parse_err      <= 1'b0;
        end else begin
            out_bit    <= 1'b0;
            data_ready <= 1'b0;
            parse_err  <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_type_ok) begin
                            r_is_data <= (rx_byte == DATA_TYPE);
                            r_state   <= S_NLEN;
                        end else begin
                            parse_err <= 1'b1;
                        end
                    end
                    S_NLEN: begin
                        if (rx_byte == 8'd0) begin
                            parse_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end else if (rx_byte > MAX_N) begin
                            // Oversize names are still consumed so the stream stays framed.
                            parse_err <= 1'b1;
                            r_cnt     <= rx_byte;
                            r_state   <= S_DROP;
                        end else begin
                            r_cnt   <= rx_byte;
                            r_nlen  <= rx_byte[2:0];
                            r_idx   <= 3'd0;
                            r_name  <= 64'd0;
                            r_state <= S_NAME;
                        end
                    end
                    S_NAME: begin
                        r_name <= w_name_next;
                        r_idx  <= r_idx + 3'd1;
                        r_cnt  <= r_cnt - 8'd1;
                        if (w_last) begin
                            if (r_is_data) begin
                                data_in_prefix <= w_name_next;
                                data_in_len    <= w_len;
                                r_state        <= S_CLEN;
                            end else begin
                                prefix  <= w_name_next;
                                len     <= w_len;
                                out_bit <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_CLEN: begin
                        if (rx_byte == 8'd0) begin
                            parse_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_cnt   <= rx_byte;
                            r_state <= S_CONTENT;
                        end
                    end
                    S_CONTENT: begin
                        in_data    <= rx_byte;
                        data_ready <= 1'b1;
                        r_cnt      <= r_cnt - 8'd1;
                        if (w_last) r_state <= S_IDLE;
                    end
                    S_DROP: begin
                        r_cnt <= r_cnt - 8'd1;
                        if (w_last) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ndn_packet_parser.sv
// Scoreboard bench for ndn_packet_parser: expected strobes are queued as
// stimulus is driven and matched by a monitor on the falling clock edge.
module tb_ndn_packet_parser;

    localparam int K_INT     = 0;
    localparam int K_DAT     = 1;
    localparam int K_ERR     = 2;
    localparam int K_ERR_PFX = 3;

    typedef struct {
        int          kind;
        logic [63:0] pfx;
        logic [5:0]  ln;
        logic [7:0]  dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic        ready_for_data;
    logic [63:0] prefix;
    logic [5:0]  len;
    logic        out_bit;
    logic [63:0] data_in_prefix;
    logic [5:0]  data_in_len;
    logic        data_ready;
    logic [7:0]  in_data;
    logic        parse_err;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q_exp[$];

    ndn_packet_parser dut (
        .clk            (clk),
        .rst            (rst),
        .rx_byte        (rx_byte),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .ready_for_data (ready_for_data),
        .prefix         (prefix),
        .len            (len),
        .out_bit        (out_bit),
        .data_in_prefix (data_in_prefix),
        .data_in_len    (data_in_len),
        .data_ready     (data_ready),
        .in_data        (in_data),
        .parse_err      (parse_err)
    );

    always #5 clk = ~clk;

    // Monitor: every strobe cycle must match the oldest queued expectation.
    exp_t m_e;
    int   m_kind;
    logic m_bad;
    always @(negedge clk) begin
        if (rst === 1'b1 && (out_bit || data_ready || parse_err)) begin
            m_kind = out_bit ? K_INT : (data_ready ? K_DAT : K_ERR);
            n_cmp++;
            if (q_exp.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: got kind %0d (out_bit=%b data_ready=%b parse_err=%b), expected no strobe",
                         m_kind, out_bit, data_ready, parse_err);
            end else begin
                m_e = q_exp.pop_front();
                case (m_e.kind)
                    K_INT:   m_bad = !(out_bit && !data_ready && !parse_err &&
                                       prefix === m_e.pfx && len === m_e.ln);
                    K_DAT:   m_bad = !(data_ready && !out_bit && !parse_err && in_data === m_e.dat &&
                                       data_in_prefix === m_e.pfx && data_in_len === m_e.ln);
                    K_ERR:   m_bad = !(parse_err && !out_bit && !data_ready);
                    default: m_bad = !(parse_err && !out_bit && !data_ready &&
                                       data_in_prefix === m_e.pfx && data_in_len === m_e.ln);
                endcase
                if (m_bad) begin
                    n_err++;
                    $display("FAIL strobe_kind%0d: got out_bit=%b data_ready=%b parse_err=%b prefix=%h len=%0d data_in_prefix=%h data_in_len=%0d in_data=%h, expected pfx=%h len=%0d dat=%h",
                             m_e.kind, out_bit, data_ready, parse_err, prefix, len, data_in_prefix,
                             data_in_len, in_data, m_e.pfx, m_e.ln, m_e.dat);
                end
            end
        end
    end

    task automatic push(input int kind, input logic [63:0] pfx, input logic [5:0] ln, input logic [7:0] dat);
        exp_t e;
        e.kind = kind;
        e.pfx  = pfx;
        e.ln   = ln;
        e.dat  = dat;
        q_exp.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        int   t;
        ok = 1'b0;
        t  = 0;
        rx_byte  = b;
        rx_valid = 1'b1;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: rx_ready stayed 0 for byte %h, expected 1 within 50 cycles", b);
        end
    endtask

    task automatic send_q(input logic [7:0] pkt[$]);
        foreach (pkt[i]) send_byte(pkt[i]);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; ready_for_data = 1'b1;
        #3 rst = 1'b0;
        #9;
        n_cmp++;
        if ({prefix, len, data_in_prefix, data_in_len, in_data} !== '0) begin
            n_err++;
            $display("FAIL reset_regs: got prefix=%h len=%0d dprefix=%h dlen=%0d in_data=%h, expected all 0",
                     prefix, len, data_in_prefix, data_in_len, in_data);
        end
        n_cmp++;
        if ({out_bit, data_ready, parse_err} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_strobes: got %b, expected 000", {out_bit, data_ready, parse_err});
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (rx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rx_ready: got %b, expected 1", rx_ready);
        end
    endtask

    task automatic test_interest;
        logic [7:0] p[$];
        push(K_INT, 64'hAABBCC0000000000, 6'd24, 8'h00);
        p = '{8'h05, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        send_q(p);
        idle(3);
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL interest_pending: got %0d outstanding events, expected 0", q_exp.size());
            q_exp.delete();
        end
    endtask

    task automatic test_data_backpressure;
        logic [7:0] p[$];
        push(K_DAT, 64'h1234000000000000, 6'd16, 8'hD0);
        push(K_DAT, 64'h1234000000000000, 6'd16, 8'hD1);
        push(K_DAT, 64'h1234000000000000, 6'd16, 8'hD2);
        p = '{8'h06, 8'h02, 8'h12, 8'h34, 8'h03, 8'hD0};
        send_q(p);
        ready_for_data = 1'b0;
        rx_byte        = 8'hD1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rx_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_rx_ready: cycle %0d got %b, expected 0", c, rx_ready);
            end
            n_cmp++;
            if (data_in_prefix !== 64'h1234000000000000 || data_in_len !== 6'd16) begin
                n_err++;
                $display("FAIL stall_dprefix: got %h/%0d, expected 1234000000000000/16", data_in_prefix, data_in_len);
            end
            @(posedge clk);
            #1;
        end
        ready_for_data = 1'b1;
        send_byte(8'hD1);
        send_byte(8'hD2);
        idle(3);
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL data_pending: got %0d outstanding events, expected 0", q_exp.size());
            q_exp.delete();
        end
    endtask

    task automatic test_bad_type;
        logic [7:0] p[$];
        push(K_ERR, 64'd0, 6'd0, 8'h00);
        push(K_INT, 64'hC300000000000000, 6'd8, 8'h00);
        p = '{8'h07, 8'h05, 8'h01, 8'hC3};
        send_q(p);
        idle(3);
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL badtype_pending: got %0d outstanding events, expected 0", q_exp.size());
            q_exp.delete();
        end
    endtask

    task automatic test_oversize;
        logic [7:0] p[$];
        push(K_ERR, 64'd0, 6'd0, 8'h00);
        push(K_INT, 64'h7F00000000000000, 6'd8, 8'h00);
        p = '{8'h05, 8'h09, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h06, 8'h01, 8'h05, 8'h00,
              8'h05, 8'h01, 8'h7F};
        send_q(p);
        idle(3);
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL oversize_pending: got %0d outstanding events, expected 0", q_exp.size());
            q_exp.delete();
        end
    endtask

    task automatic test_boundaries;
        logic [7:0] p[$];
        push(K_INT, 64'h1122334455667700, 6'd56, 8'h00);
        p = '{8'h05, 8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        send_q(p);
        push(K_ERR, 64'd0, 6'd0, 8'h00);
        push(K_INT, 64'hAB00000000000000, 6'd8, 8'h00);
        p = '{8'h05, 8'h00, 8'h05, 8'h01, 8'hAB};
        send_q(p);
        push(K_ERR_PFX, 64'h5A00000000000000, 6'd8, 8'h00);
        p = '{8'h06, 8'h01, 8'h5A, 8'h00};
        send_q(p);
        idle(3);
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL boundary_pending: got %0d outstanding events, expected 0", q_exp.size());
            q_exp.delete();
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] p[$];
        push(K_INT, 64'h0100000000000000, 6'd8, 8'h00);
        push(K_INT, 64'h0200000000000000, 6'd8, 8'h00);
        push(K_DAT, 64'h7788000000000000, 6'd16, 8'hE1);
        push(K_DAT, 64'h7788000000000000, 6'd16, 8'hE2);
        push(K_INT, 64'h0304050000000000, 6'd24, 8'h00);
        p = '{8'h05, 8'h01, 8'h01, 8'h05, 8'h01, 8'h02,
              8'h06, 8'h02, 8'h77, 8'h88, 8'h02, 8'hE1, 8'hE2,
              8'h05, 8'h03, 8'h03, 8'h04, 8'h05};
        send_q(p);
        idle(3);
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL b2b_pending: got %0d outstanding events, expected 0", q_exp.size());
            q_exp.delete();
        end
    endtask

    task automatic test_reset_mid_packet;
        logic [7:0] p[$];
        p = '{8'h05, 8'h03, 8'hAA, 8'hBB};
        send_q(p);
        rst = 1'b0;
        #2;
        n_cmp++;
        if ({prefix, len, data_in_prefix, data_in_len, in_data, out_bit, data_ready, parse_err} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got prefix=%h len=%0d dprefix=%h dlen=%0d in_data=%h strobes=%b, expected all 0",
                     prefix, len, data_in_prefix, data_in_len, in_data, {out_bit, data_ready, parse_err});
        end
        rx_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        push(K_INT, 64'hEE00000000000000, 6'd8, 8'h00);
        p = '{8'h05, 8'h01, 8'hEE};
        send_q(p);
        idle(3);
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL midreset_pending: got %0d outstanding events, expected 0", q_exp.size());
            q_exp.delete();
        end
    endtask

    initial begin
        test_reset;
        test_interest;
        test_data_backpressure;
        test_bad_type;
        test_oversize;
        test_boundaries;
        test_back_to_back;
        test_reset_mid_packet;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
